// File: rtl/params_pkg.sv
// ============================================================================
// params_pkg -- shared widths, AXI response/burst encodings and FSM states
//               for the MM2S read-only memory slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

package params_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/axi_rd_addr_gen.sv
// ============================================================================
// axi_rd_addr_gen -- combinational next-beat address for FIXED/INCR/WRAP.
// WRAP support is compiled in only with AXI_MM2S_SLAVE_WRAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_rd_addr_gen
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_burst,
    input  logic [7:0]            i_len,
    output logic [ADDR_WIDTH-1:0] o_next_addr
);

    logic [ADDR_WIDTH-1:0] incr_addr;
    assign incr_addr = i_addr + ADDR_WIDTH'(4);

`ifdef AXI_MM2S_SLAVE_WRAP_EN
    // Legal wrap lengths make (len+1)*4-1 equal to {len,2'b11}.
    logic [ADDR_WIDTH-1:0] wrap_mask;
    assign wrap_mask = {{(ADDR_WIDTH-10){1'b0}}, i_len, 2'b11};
`else
    logic unused_len;
    assign unused_len = ^i_len;
`endif

    always_comb begin
        o_next_addr = incr_addr;
        if (i_burst == BURST_FIXED) begin
            o_next_addr = i_addr;
        end
`ifdef AXI_MM2S_SLAVE_WRAP_EN
        else if (i_burst == BURST_WRAP) begin
            o_next_addr = (i_addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/axi_mm2s_mem_slave.sv
// ============================================================================
// axi_mm2s_mem_slave -- AXI4 read-only memory slave with backdoor preload,
// one outstanding burst. WRAP bursts served when AXI_MM2S_SLAVE_WRAP_EN set.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_mm2s_mem_slave
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         axi_aclk,
    input  logic                         axi_resetn,
    input  logic [ADDR_WIDTH-1:0]        m_axi_mm2s_araddr,
    input  logic [7:0]                   m_axi_mm2s_arlen,
    input  logic [2:0]                   m_axi_mm2s_arsize,
    input  logic [1:0]                   m_axi_mm2s_arburst,
    input  logic [2:0]                   m_axi_mm2s_arprot,
    input  logic [3:0]                   m_axi_mm2s_arcache,
    input  logic                         m_axi_mm2s_arvalid,
    output logic                         m_axi_mm2s_arready,
    output logic [DATA_WIDTH-1:0]        m_axi_mm2s_rdata,
    output logic [1:0]                   m_axi_mm2s_rresp,
    output logic                         m_axi_mm2s_rlast,
    output logic                         m_axi_mm2s_rvalid,
    input  logic                         m_axi_mm2s_rready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [15:0]                  burst_cnt
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
    logic [7:0]            len_q, len_d, beat_q, beat_d;
    logic [1:0]            burst_q, burst_d;
    logic                  slverr_q, slverr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [15:0]           burst_cnt_q, burst_cnt_d;

    logic                  ar_slverr;
    logic                  beat_decerr;
    logic                  load_beat;
    logic [IDX_W-1:0]      word_idx;
    logic                  unused_ar;

    assign unused_ar = ^{m_axi_mm2s_arprot, m_axi_mm2s_arcache};

    axi_rd_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .i_addr      (addr_q),
        .i_burst     (burst_q),
        .i_len       (len_q),
        .o_next_addr (addr_next)
    );

    // Burst-level error is decided once at the AR handshake.
    always_comb begin
        ar_slverr = (m_axi_mm2s_arsize != 3'd2) || (m_axi_mm2s_arburst == 2'd3);
        if (m_axi_mm2s_arburst == BURST_WRAP) begin
`ifdef AXI_MM2S_SLAVE_WRAP_EN
            if (!(m_axi_mm2s_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                (m_axi_mm2s_araddr[1:0] != 2'b00)) begin
                ar_slverr = 1'b1;
            end
`else
            ar_slverr = 1'b1;
`endif
        end
    end

    assign word_idx    = addr_q[IDX_W+1:2];
    assign beat_decerr = |addr_q[ADDR_WIDTH-1:IDX_W+2];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        burst_d     = burst_q;
        slverr_d    = slverr_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        burst_cnt_d = burst_cnt_q;
        load_beat   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (m_axi_mm2s_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    state_d   = ST_BURST;
                    addr_d    = m_axi_mm2s_araddr;
                    len_d     = m_axi_mm2s_arlen;
                    burst_d   = m_axi_mm2s_arburst;
                    slverr_d  = ar_slverr;
                    beat_d    = 8'd0;
                end
            end
            ST_BURST: begin
                if (rvalid_q && m_axi_mm2s_rready && rlast_q) begin
                    rvalid_d    = 1'b0;
                    rlast_d     = 1'b0;
                    state_d     = ST_IDLE;
                    arready_d   = 1'b1;
                    burst_cnt_d = (burst_cnt_q == 16'hFFFF) ? burst_cnt_q
                                                            : burst_cnt_q + 16'd1;
                end else if (!rvalid_q || m_axi_mm2s_rready) begin
                    load_beat = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output registers only reload when empty or drained, so a stall holds them.
        if (load_beat) begin
            rvalid_d = 1'b1;
            rlast_d  = (beat_q == len_q);
            beat_d   = beat_q + 8'd1;
            addr_d   = addr_next;
            if (slverr_q) begin
                rresp_d = RESP_SLVERR;
                rdata_d = '0;
            end else if (beat_decerr) begin
                rresp_d = RESP_DECERR;
                rdata_d = '0;
            end else begin
                rresp_d = RESP_OKAY;
                rdata_d = mem_q[word_idx];
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            burst_q     <= '0;
            slverr_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            burst_q     <= burst_d;
            slverr_q    <= slverr_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Contents survive reset; a same-edge write is seen only by later fetches.
    always_ff @(posedge axi_aclk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign m_axi_mm2s_arready = arready_q;
    assign m_axi_mm2s_rvalid  = rvalid_q;
    assign m_axi_mm2s_rlast   = rlast_q;
    assign m_axi_mm2s_rdata   = rdata_q;
    assign m_axi_mm2s_rresp   = rresp_q;
    assign burst_cnt          = burst_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_mm2s_mem_slave.sv
// ============================================================================
// tb_axi_mm2s_mem_slave -- directed self-checking bench for the MM2S slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_mm2s_mem_slave;

    localparam int MEM_DEPTH = 1024;

    logic        axi_aclk = 1'b0;
    logic        axi_resetn = 1'b0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'd1;
    logic [2:0]  arprot = '0;
    logic [3:0]  arcache = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        mem_we = 1'b0;
    logic [9:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;
    logic [15:0] burst_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] exp_cnt = '0;

    always #5 axi_aclk = ~axi_aclk;

    axi_mm2s_mem_slave #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .axi_aclk           (axi_aclk),
        .axi_resetn         (axi_resetn),
        .m_axi_mm2s_araddr  (araddr),
        .m_axi_mm2s_arlen   (arlen),
        .m_axi_mm2s_arsize  (arsize),
        .m_axi_mm2s_arburst (arburst),
        .m_axi_mm2s_arprot  (arprot),
        .m_axi_mm2s_arcache (arcache),
        .m_axi_mm2s_arvalid (arvalid),
        .m_axi_mm2s_arready (arready),
        .m_axi_mm2s_rdata   (rdata),
        .m_axi_mm2s_rresp   (rresp),
        .m_axi_mm2s_rlast   (rlast),
        .m_axi_mm2s_rvalid  (rvalid),
        .m_axi_mm2s_rready  (rready),
        .mem_we             (mem_we),
        .mem_waddr          (mem_waddr),
        .mem_wdata          (mem_wdata),
        .burst_cnt          (burst_cnt)
    );

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge axi_aclk);
        mem_we = 1'b1; mem_waddr = idx; mem_wdata = data;
        @(negedge axi_aclk);
        mem_we = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        int t = 0;
        @(negedge axi_aclk);
        araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
        while (!arready && t < 50) begin
            @(negedge axi_aclk);
            t++;
        end
        if (!arready) begin
            n_cmp++; n_fail++;
            $display("FAIL ar_timeout: arready=%b required 1", arready);
        end
        @(posedge axi_aclk);
        #1 arvalid = 1'b0;
    endtask

    task automatic get_beat(output logic [31:0] d, output logic [1:0] r,
                            output logic l, output int waits);
        waits = 0;
        @(negedge axi_aclk);
        while (!rvalid && waits < 50) begin
            waits++;
            @(negedge axi_aclk);
        end
        if (!rvalid) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_timeout: rvalid=%b required 1", rvalid);
        end
        d = rdata; r = rresp; l = rlast;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge axi_aclk);
        n_cmp++;
        if ({arready, rvalid, rlast, rresp, rdata, burst_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: arready=%b rvalid=%b rlast=%b rresp=%0d rdata=%h cnt=%0d required all 0",
                     arready, rvalid, rlast, rresp, rdata, burst_cnt);
        end
        axi_resetn = 1'b1;
        #1;
        n_cmp++;
        if (arready !== 1'b0) begin
            n_fail++; $display("FAIL reset_arready_early: got %b required 0", arready);
        end
        @(posedge axi_aclk); #1;
        n_cmp++;
        if (arready !== 1'b1) begin
            n_fail++; $display("FAIL reset_arready_rise: got %b required 1", arready);
        end
    endtask

    task automatic test_incr();
        logic [31:0] d; logic [1:0] r; logic l; int w; int tw = 0;
        send_ar(32'h0, 8'd15, 3'd2, 2'd1);
        @(negedge axi_aclk);
        n_cmp++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            n_fail++; $display("FAIL incr_latency: rvalid=%b arready=%b required 0 0", rvalid, arready);
        end
        for (int k = 0; k < 16; k++) begin
            get_beat(d, r, l, w);
            tw += w;
            n_cmp++;
            if (d !== 32'hA000_0000 + k || r !== 2'd0 || l !== (k == 15)) begin
                n_fail++;
                $display("FAIL incr_beat%0d: data=%h resp=%0d last=%b required %h 0 %b",
                         k, d, r, l, 32'hA000_0000 + k, (k == 15));
            end
        end
        n_cmp++;
        if (tw !== 0) begin
            n_fail++; $display("FAIL incr_back_to_back: bubbles=%0d required 0", tw);
        end
        @(negedge axi_aclk);
        exp_cnt++;
        n_cmp++;
        if (arready !== 1'b1 || rvalid !== 1'b0 || burst_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL incr_done: arready=%b rvalid=%b cnt=%0d required 1 0 %0d",
                     arready, rvalid, burst_cnt, exp_cnt);
        end
    endtask

    task automatic test_fixed();
        logic [31:0] d; logic [1:0] r; logic l; int w;
        send_ar(32'h10, 8'd3, 3'd2, 2'd0);
        for (int k = 0; k < 4; k++) begin
            get_beat(d, r, l, w);
            n_cmp++;
            if (d !== 32'hA000_0004 || r !== 2'd0 || l !== (k == 3)) begin
                n_fail++;
                $display("FAIL fixed_beat%0d: data=%h resp=%0d last=%b required a0000004 0 %b",
                         k, d, r, l, (k == 3));
            end
        end
        @(negedge axi_aclk);
        exp_cnt++;
        n_cmp++;
        if (burst_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL fixed_cnt: got %0d required %0d", burst_cnt, exp_cnt);
        end
    endtask

    task automatic test_decerr();
        logic [31:0] d; logic [1:0] r; logic l; int w;
        logic [31:0] ed [4] = '{32'hB000_03FE, 32'hB000_03FF, 32'h0, 32'h0};
        logic [1:0]  er [4] = '{2'd0, 2'd0, 2'd3, 2'd3};
        send_ar((MEM_DEPTH - 2) * 4, 8'd3, 3'd2, 2'd1);
        for (int k = 0; k < 4; k++) begin
            get_beat(d, r, l, w);
            n_cmp++;
            if (d !== ed[k] || r !== er[k] || l !== (k == 3)) begin
                n_fail++;
                $display("FAIL decerr_beat%0d: data=%h resp=%0d last=%b required %h %0d %b",
                         k, d, r, l, ed[k], er[k], (k == 3));
            end
        end
        @(negedge axi_aclk);
        exp_cnt++;
    endtask

    task automatic test_slverr();
        logic [31:0] d; logic [1:0] r; logic l; int w;
        send_ar(32'h0, 8'd1, 3'd1, 2'd1);
        for (int k = 0; k < 2; k++) begin
            get_beat(d, r, l, w);
            n_cmp++;
            if (d !== 32'h0 || r !== 2'd2 || l !== (k == 1)) begin
                n_fail++;
                $display("FAIL slverr_beat%0d: data=%h resp=%0d last=%b required 0 2 %b",
                         k, d, r, l, (k == 1));
            end
        end
        @(negedge axi_aclk);
        exp_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic [1:0] r; logic l; int w;
`ifdef AXI_MM2S_SLAVE_WRAP_EN
        logic [31:0] ed [4] = '{32'hA000_0006, 32'hA000_0007, 32'hA000_0004, 32'hA000_0005};
        logic [1:0]  er = 2'd0;
`else
        logic [31:0] ed [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
        logic [1:0]  er = 2'd2;
`endif
        send_ar(32'h18, 8'd3, 3'd2, 2'd2);
        for (int k = 0; k < 4; k++) begin
            get_beat(d, r, l, w);
            n_cmp++;
            if (d !== ed[k] || r !== er || l !== (k == 3)) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: data=%h resp=%0d last=%b required %h %0d %b",
                         k, d, r, l, ed[k], er, (k == 3));
            end
        end
        @(negedge axi_aclk);
        exp_cnt++;
        n_cmp++;
        if (burst_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL wrap_cnt: got %0d required %0d", burst_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        int k = 0; int c = 0;
        logic held = 1'b0;
        logic [31:0] hd = '0; logic [1:0] hr = '0; logic hl = 1'b0;
        send_ar(32'h0, 8'd7, 3'd2, 2'd1);
        while (k < 8 && c < 200) begin
            @(negedge axi_aclk);
            if (held) begin
                n_cmp++;
                if (rvalid !== 1'b1 || rdata !== hd || rresp !== hr || rlast !== hl) begin
                    n_fail++;
                    $display("FAIL stall_stable: valid=%b data=%h resp=%0d last=%b required 1 %h %0d %b",
                             rvalid, rdata, rresp, rlast, hd, hr, hl);
                end
            end
            rready = (c % 4 == 0) || (c % 4 == 3);
            c++;
            held = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    n_cmp++;
                    if (rdata !== 32'hA000_0000 + k || rresp !== 2'd0 || rlast !== (k == 7)) begin
                        n_fail++;
                        $display("FAIL bp_beat%0d: data=%h resp=%0d last=%b required %h 0 %b",
                                 k, rdata, rresp, rlast, 32'hA000_0000 + k, (k == 7));
                    end
                    k++;
                end else begin
                    held = 1'b1; hd = rdata; hr = rresp; hl = rlast;
                end
            end
        end
        if (k != 8) begin
            n_cmp++; n_fail++;
            $display("FAIL bp_timeout: beats=%0d required 8", k);
        end
        rready = 1'b1;
        @(negedge axi_aclk);
        exp_cnt++;
        n_cmp++;
        if (burst_cnt !== exp_cnt || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: cnt=%0d rvalid=%b required %0d 0", burst_cnt, rvalid, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d; logic [1:0] r; logic l; int w;
        rready = 1'b1;
        send_ar(32'h0, 8'd7, 3'd2, 2'd1);
        get_beat(d, r, l, w);
        get_beat(d, r, l, w);
        @(negedge axi_aclk);
        axi_resetn = 1'b0;
        #1;
        exp_cnt = '0;
        n_cmp++;
        if ({arready, rvalid, rlast, rresp, rdata, burst_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midreset_vals: arready=%b rvalid=%b rlast=%b rresp=%0d rdata=%h cnt=%0d required all 0",
                     arready, rvalid, rlast, rresp, rdata, burst_cnt);
        end
        repeat (2) @(negedge axi_aclk);
        axi_resetn = 1'b1;
        #1;
        n_cmp++;
        if (arready !== 1'b0) begin
            n_fail++; $display("FAIL midreset_arready_early: got %b required 0", arready);
        end
        @(posedge axi_aclk); #1;
        n_cmp++;
        if (arready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_arready_rise: got %b required 1", arready);
        end
        send_ar(32'h20, 8'd3, 3'd2, 2'd1);
        for (int k = 0; k < 4; k++) begin
            get_beat(d, r, l, w);
            n_cmp++;
            if (d !== 32'hA000_0008 + k || r !== 2'd0 || l !== (k == 3)) begin
                n_fail++;
                $display("FAIL postreset_beat%0d: data=%h resp=%0d last=%b required %h 0 %b",
                         k, d, r, l, 32'hA000_0008 + k, (k == 3));
            end
        end
        @(negedge axi_aclk);
        exp_cnt++;
        n_cmp++;
        if (burst_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL postreset_cnt: got %0d required %0d", burst_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 16; i++) begin
            preload(10'(i), 32'hA000_0000 + i);
        end
        preload(10'(MEM_DEPTH - 2), 32'hB000_03FE);
        preload(10'(MEM_DEPTH - 1), 32'hB000_03FF);
        test_incr();
        test_fixed();
        test_decerr();
        test_slverr();
        test_wrap();
        test_backpressure();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
